// File: rtl/instruction_fetch_system_pkg.sv
// Shared definitions for the instruction fetch front end: state encoding,
// memory bus polarities and a width helper for small counters.
package instruction_fetch_system_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_e;

    // Chip select is active-low; the unit only ever reads memory
    localparam logic CS_ACTIVE   = 1'b0;
    localparam logic CS_INACTIVE = 1'b1;
    localparam logic MEM_READ    = 1'b0;

    // Bits needed to index n items, never less than one bit
    function automatic int safeWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/instruction_fetch_system_if.sv
// Memory read bus plus the instruction valid/ready handshake toward the
// control unit. The fetch unit is the master of both.
interface instruction_fetch_system_if #(
    parameter int DATA_W      = 8,
    parameter int INSTR_BYTES = 2,
    parameter int ADDR_W      = 16
) ();

    logic [DATA_W-1:0]             Mem_Data;
    logic [ADDR_W-1:0]             Mem_Address;
    logic                          Mem_CS;
    logic                          Mem_WR;
    logic [DATA_W*INSTR_BYTES-1:0] IROut;
    logic                          IR_Valid;
    logic                          IR_Ready;

    modport master (
        input  Mem_Data,
        input  IR_Ready,
        output Mem_Address,
        output Mem_CS,
        output Mem_WR,
        output IROut,
        output IR_Valid
    );

    modport slave (
        output Mem_Data,
        output IR_Ready,
        input  Mem_Address,
        input  Mem_CS,
        input  Mem_WR,
        input  IROut,
        input  IR_Valid
    );

endinterface

// File: rtl/instruction_fetch_system_ir_slot_assembler.sv
// Instruction register built from INSTR_BYTES unit-wide slots. Slot 0 is the
// least significant unit. Only the addressed slot changes on a write; the
// others keep whatever they last held.
module ir_slot_assembler
    import instruction_fetch_system_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int INSTR_BYTES = 2,
    parameter int SLOT_W      = safeWidth(INSTR_BYTES)
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          wrEn_i,
    input  logic [SLOT_W-1:0]             slotIdx_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic [DATA_W*INSTR_BYTES-1:0] word_o
);

    logic [DATA_W*INSTR_BYTES-1:0] word_q;
    logic [DATA_W*INSTR_BYTES-1:0] word_d;

    // Merge the incoming unit into the selected slot
    always_comb begin
        word_d = word_q;
        if (wrEn_i) begin
            for (int s = 0; s < INSTR_BYTES; s++) begin
                if (slotIdx_i == SLOT_W'(s)) begin
                    word_d[s*DATA_W +: DATA_W] = data_i;
                end
            end
        end
    end

    // Instruction register, cleared only by reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/instruction_fetch_system.sv
// Instruction fetch front end: walks PC through byte-wide memory, packs
// INSTR_BYTES consecutive units into IROut and hands the word over with a
// valid/ready handshake. Supports redirects and fixed memory latency.
module instruction_fetch_system
    import instruction_fetch_system_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                INSTR_BYTES = 2,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_LATENCY = 0
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Run,
    input  logic                       Redirect,
    input  logic [ADDR_W-1:0]          Redirect_Addr,
    output logic [ADDR_W-1:0]          PC,
    output logic                       Busy,
    instruction_fetch_system_if.master bus
);

    localparam int SLOT_W   = safeWidth(INSTR_BYTES);
    localparam int LAT_W    = safeWidth(MEM_LATENCY);
    localparam bit ZERO_LAT = (MEM_LATENCY == 0);
    localparam int LAT_LAST = ZERO_LAT ? 0 : MEM_LATENCY - 1;

    fetch_state_e                  state_q;
    fetch_state_e                  state_d;
    logic [ADDR_W-1:0]             pc_q;
    logic [ADDR_W-1:0]             pc_d;
    logic [SLOT_W-1:0]             slot_q;
    logic [SLOT_W-1:0]             slot_d;
    logic [LAT_W-1:0]              latCnt_q;
    logic [LAT_W-1:0]              latCnt_d;

    logic                          lastSlot;
    logic                          latDone;
    logic                          captureEn;
    logic                          handshake;
    logic [DATA_W*INSTR_BYTES-1:0] irWord;

    assign lastSlot  = (slot_q == SLOT_W'(INSTR_BYTES - 1));
    assign latDone   = (latCnt_q == LAT_W'(LAT_LAST));
    assign handshake = (state_q == S_HOLD) && bus.IR_Ready;

    // A unit is captured at the end of the cycle in which memory data is
    // valid; a redirect in that same cycle discards it
    always_comb begin
        captureEn = 1'b0;
        if (!Redirect) begin
            if (ZERO_LAT) begin
                captureEn = (state_q == S_FETCH);
            end else begin
                captureEn = (state_q == S_WAIT) && latDone;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; a redirect restarts fetching from any state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ZERO_LAT) begin
                    if (captureEn && lastSlot) begin
                        state_d = S_HOLD;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (captureEn) begin
                    state_d = lastSlot ? S_HOLD : S_FETCH;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    state_d = Run ? S_FETCH : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (Redirect) begin
            state_d = Run ? S_FETCH : S_IDLE;
        end
    end

    // Bus and status outputs decoded from the current state
    always_comb begin
        bus.Mem_Address = pc_q;
        bus.Mem_WR      = MEM_READ;
        bus.Mem_CS      = CS_INACTIVE;
        bus.IR_Valid    = 1'b0;
        Busy            = 1'b0;
        PC              = pc_q;
        bus.IROut       = irWord;
        unique case (state_q)
            S_FETCH, S_WAIT: begin
                bus.Mem_CS = CS_ACTIVE;
                Busy       = 1'b1;
            end
            S_HOLD: begin
                bus.IR_Valid = 1'b1;
            end
            default: ;
        endcase
    end

    // PC, slot index and latency counter updates
    always_comb begin
        pc_d     = pc_q;
        slot_d   = slot_q;
        latCnt_d = latCnt_q;
        if (captureEn) begin
            pc_d     = pc_q + ADDR_W'(1);
            slot_d   = lastSlot ? '0 : slot_q + SLOT_W'(1);
            latCnt_d = '0;
        end else if (state_q == S_WAIT) begin
            latCnt_d = latCnt_q + LAT_W'(1);
        end else begin
            latCnt_d = '0;
        end
        if (Redirect) begin
            pc_d     = Redirect_Addr;
            slot_d   = '0;
            latCnt_d = '0;
        end
    end

    // Datapath registers; reset wins over any redirect
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q     <= RESET_PC;
            slot_q   <= '0;
            latCnt_q <= '0;
        end else begin
            pc_q     <= pc_d;
            slot_q   <= slot_d;
            latCnt_q <= latCnt_d;
        end
    end

    ir_slot_assembler #(
        .DATA_W      (DATA_W),
        .INSTR_BYTES (INSTR_BYTES),
        .SLOT_W      (SLOT_W)
    ) u_assembler (
        .Clock     (Clock),
        .Reset     (Reset),
        .wrEn_i    (captureEn),
        .slotIdx_i (slot_q),
        .data_i    (bus.Mem_Data),
        .word_o    (irWord)
    );

endmodule

// File: tb/tb_instruction_fetch_system.sv
// Testbench: one zero-latency fetch unit and one with two cycles of memory
// latency, both reading the same byte memory held here.
module tb_instruction_fetch_system;

    localparam int DATA_W      = 8;
    localparam int INSTR_BYTES = 2;
    localparam int ADDR_W      = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    logic        rst0 = 1'b1, run0 = 1'b0, redirect0 = 1'b0, ready0 = 1'b0;
    logic [15:0] redirAddr0 = '0;
    logic [15:0] pc0;
    logic        busy0;

    logic        rst2 = 1'b1, run2 = 1'b0, redirect2 = 1'b0, ready2 = 1'b0;
    logic [15:0] redirAddr2 = '0;
    logic [15:0] pc2;
    logic        busy2;

    logic [7:0]  pipeA = '0, pipeB = '0;

    int assertCount = 0;
    int failCount   = 0;

    instruction_fetch_system_if #(.DATA_W(DATA_W), .INSTR_BYTES(INSTR_BYTES), .ADDR_W(ADDR_W)) bus0 ();
    instruction_fetch_system_if #(.DATA_W(DATA_W), .INSTR_BYTES(INSTR_BYTES), .ADDR_W(ADDR_W)) bus2 ();

    // Combinational memory for the zero-latency unit
    assign bus0.Mem_Data = mem[bus0.Mem_Address];
    assign bus0.IR_Ready = ready0;

    // Two-stage delayed memory: data for an address appears two edges later
    always @(posedge clk) begin
        pipeA <= mem[bus2.Mem_Address];
        pipeB <= pipeA;
    end
    assign bus2.Mem_Data = pipeB;
    assign bus2.IR_Ready = ready2;

    instruction_fetch_system #(
        .DATA_W(DATA_W), .INSTR_BYTES(INSTR_BYTES), .ADDR_W(ADDR_W),
        .RESET_PC(16'h0000), .MEM_LATENCY(0)
    ) dut0 (
        .Clock(clk), .Reset(rst0), .Run(run0), .Redirect(redirect0),
        .Redirect_Addr(redirAddr0), .PC(pc0), .Busy(busy0), .bus(bus0.master)
    );

    instruction_fetch_system #(
        .DATA_W(DATA_W), .INSTR_BYTES(INSTR_BYTES), .ADDR_W(ADDR_W),
        .RESET_PC(16'h0000), .MEM_LATENCY(2)
    ) dut2 (
        .Clock(clk), .Reset(rst2), .Run(run2), .Redirect(redirect2),
        .Redirect_Addr(redirAddr2), .PC(pc2), .Busy(busy2), .bus(bus2.master)
    );

    // Advance to the falling edge n times; outputs are sampled and inputs
    // changed there, away from the rising edge
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Bounded wait for the zero-latency unit to present a word
    task automatic waitValid0(output int cycles);
        cycles = 0;
        do begin
            applyStimulus(1);
            cycles++;
        end while (!bus0.IR_Valid && cycles < 20);
    endtask

    // Expected instruction starting at address a (first unit least significant)
    function automatic logic [15:0] wordAt(input logic [15:0] a);
        logic [15:0] b;
        b = a + 16'd1;
        return {mem[b], mem[a]};
    endfunction

    initial begin
        int          waited;
        int          hsCount;
        logic [15:0] r;
        logic [15:0] modelPc;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h56;

        // Reset with a redirect pending: reset must win
        run0 = 1'b1; redirect0 = 1'b1; redirAddr0 = 16'h00AA; ready0 = 1'b0;
        applyStimulus(2);
        checkOutput("rst pc", pc0, 16'h0000);
        checkOutput("rst irout", bus0.IROut, 16'h0000);
        checkOutput("rst valid", bus0.IR_Valid, 1'b0);
        checkOutput("rst cs", bus0.Mem_CS, 1'b1);
        checkOutput("rst wr", bus0.Mem_WR, 1'b0);
        checkOutput("rst busy", busy0, 1'b0);
        checkOutput("rst2 cs", bus2.Mem_CS, 1'b1);

        // First instruction: valid on the third cycle after reset release
        rst0 = 1'b0; redirect0 = 1'b0;
        applyStimulus(1);
        checkOutput("c1 busy", busy0, 1'b1);
        checkOutput("c1 cs", bus0.Mem_CS, 1'b0);
        checkOutput("c1 addr", bus0.Mem_Address, 16'h0000);
        checkOutput("c1 valid", bus0.IR_Valid, 1'b0);
        applyStimulus(1);
        checkOutput("c2 pc", pc0, 16'h0001);
        checkOutput("c2 addr", bus0.Mem_Address, 16'h0001);
        checkOutput("c2 valid", bus0.IR_Valid, 1'b0);
        applyStimulus(1);
        checkOutput("c3 valid", bus0.IR_Valid, 1'b1);
        checkOutput("c3 irout", bus0.IROut, 16'h1234);
        checkOutput("c3 pc", pc0, 16'h0002);
        checkOutput("c3 cs", bus0.Mem_CS, 1'b1);
        checkOutput("c3 busy", busy0, 1'b0);
        applyStimulus(1);
        checkOutput("hold valid", bus0.IR_Valid, 1'b1);
        checkOutput("hold irout", bus0.IROut, 16'h1234);

        // Back-to-back with ready high: next word 3 cycles after the handshake
        ready0 = 1'b1;
        waitValid0(waited);
        checkOutput("b2b latency", waited, 3);
        checkOutput("b2b irout", bus0.IROut, 16'h5678);
        checkOutput("b2b pc", pc0, 16'h0004);
        run0 = 1'b0;
        applyStimulus(1);
        checkOutput("idle valid", bus0.IR_Valid, 1'b0);
        checkOutput("idle busy", busy0, 1'b0);
        checkOutput("idle cs", bus0.Mem_CS, 1'b1);
        checkOutput("idle pc", pc0, 16'h0004);
        ready0 = 1'b0;

        // Redirect after the first unit of a fetch has been captured
        run0 = 1'b1;
        applyStimulus(2);
        checkOutput("redir pre pc", pc0, 16'h0005);
        redirect0 = 1'b1; redirAddr0 = 16'h0040;
        applyStimulus(1);
        redirect0 = 1'b0;
        checkOutput("redir pc", pc0, 16'h0040);
        checkOutput("redir valid", bus0.IR_Valid, 1'b0);
        checkOutput("redir busy", busy0, 1'b1);
        waitValid0(waited);
        checkOutput("redir latency", waited, 2);
        checkOutput("redir irout", bus0.IROut, wordAt(16'h0040));
        checkOutput("redir pc2", pc0, 16'h0042);
        ready0 = 1'b1; run0 = 1'b0;
        applyStimulus(1);
        ready0 = 1'b0;

        // PC wraps from FFFF to 0 in the middle of an instruction
        mem[16'hFFFF] = 8'hAA; mem[0] = 8'hBB;
        run0 = 1'b1; redirect0 = 1'b1; redirAddr0 = 16'hFFFF;
        applyStimulus(1);
        redirect0 = 1'b0;
        checkOutput("wrap start pc", pc0, 16'hFFFF);
        waitValid0(waited);
        checkOutput("wrap latency", waited, 2);
        checkOutput("wrap irout", bus0.IROut, 16'hBBAA);
        checkOutput("wrap pc", pc0, 16'h0001);

        // Redirect in the same cycle as a handshake
        r = 16'($urandom);
        ready0 = 1'b1; redirect0 = 1'b1; redirAddr0 = r;
        checkOutput("hs+redir valid", bus0.IR_Valid, 1'b1);
        applyStimulus(1);
        ready0 = 1'b0; redirect0 = 1'b0;
        checkOutput("hs+redir pc", pc0, r);
        checkOutput("hs+redir valid after", bus0.IR_Valid, 1'b0);
        waitValid0(waited);
        checkOutput("hs+redir latency", waited, 2);
        checkOutput("hs+redir irout", bus0.IROut, wordAt(r));

        // Random ready/redirect traffic against a transaction-level model:
        // each accepted word is the two bytes at the model PC
        modelPc = 16'($urandom);
        redirAddr0 = modelPc; redirect0 = 1'b1; ready0 = 1'b0;
        applyStimulus(1);
        hsCount = 0;
        for (int c = 0; c < 400; c++) begin
            ready0     = 1'($urandom_range(0, 1));
            redirect0  = ($urandom_range(0, 15) == 0);
            redirAddr0 = 16'($urandom);
            if (bus0.IR_Valid && ready0) begin
                checkOutput("rand irout", bus0.IROut, wordAt(modelPc));
                checkOutput("rand pc", pc0, modelPc + 16'd2);
                modelPc = modelPc + 16'd2;
                hsCount++;
            end
            if (redirect0) modelPc = redirAddr0;
            applyStimulus(1);
        end
        redirect0 = 1'b0; ready0 = 1'b0;
        checkOutput("rand liveness", hsCount >= 20, 1'b1);

        // Two-cycle memory latency: each unit keeps CS low for three cycles
        run2 = 1'b1; ready2 = 1'b0; rst2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1);
            checkOutput("lat cs", bus2.Mem_CS, 1'b0);
            checkOutput("lat addr", bus2.Mem_Address, (k <= 3) ? 16'h0000 : 16'h0001);
            checkOutput("lat valid", bus2.IR_Valid, 1'b0);
        end
        applyStimulus(1);
        checkOutput("lat valid7", bus2.IR_Valid, 1'b1);
        checkOutput("lat irout", bus2.IROut, wordAt(16'h0000));
        checkOutput("lat pc", pc2, 16'h0002);
        checkOutput("lat cs7", bus2.Mem_CS, 1'b1);

        // Reset arriving while waiting on memory, with a redirect pending
        ready2 = 1'b1;
        applyStimulus(1);
        ready2 = 1'b0;
        applyStimulus(1);
        checkOutput("wait busy", busy2, 1'b1);
        rst2 = 1'b1; redirect2 = 1'b1; redirAddr2 = 16'h0040;
        applyStimulus(1);
        checkOutput("wrst pc", pc2, 16'h0000);
        checkOutput("wrst irout", bus2.IROut, 16'h0000);
        checkOutput("wrst valid", bus2.IR_Valid, 1'b0);
        checkOutput("wrst cs", bus2.Mem_CS, 1'b1);
        checkOutput("wrst busy", busy2, 1'b0);
        checkOutput("wrst wr", bus2.Mem_WR, 1'b0);
        rst2 = 1'b0; redirect2 = 1'b0; run2 = 1'b0;
        applyStimulus(1);
        checkOutput("wrst idle busy", busy2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
